// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } sipo_state_t;

  localparam int SIPO_WIDTH_DEF = 8;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit left-shift register, falling-edge clocked, with shift enable and
// synchronous clear. When clr and en are both high the register restarts with
// din as bit 0, so a realignment can reuse the bit sampled on the same edge.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Shift in din at the LSB, or clear (optionally restarting with din).
  always_ff @(negedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= en ? {{(WIDTH-1){1'b0}}, din} : '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: collects WIDTH MSB-first bits under
// sin_en, presents each word in a one-entry valid/ready holding register and
// flags words dropped to backpressure (sticky overrun).
// Optional feature macro: SIPO_PARITY_EN adds a trailing even-parity bit per
// word and drives parity_err; without it parity_err is tied low.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sipo_state_t      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic             sh_clr;
  logic             sh_en;
  logic             done;
  logic [WIDTH-1:0] word;

`ifdef SIPO_PARITY_EN
  logic word_par;
`else
  logic unused_sh_msb;
  assign unused_sh_msb = sh[WIDTH-1];
  assign parity_err    = 1'b0;
`endif

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk (clk),
    .rst (rst),
    .clr (sh_clr),
    .en  (sh_en),
    .din (sin),
    .q   (sh)
  );

  // Shift-register control, word-complete detection and assembled word.
  // Completion clears the register instead of shifting so IDLE never holds
  // stale bits; the completed word is taken from the pre-edge contents.
  always_comb begin
    sh_clr = 1'b0;
    sh_en  = 1'b0;
    done   = 1'b0;
    if (sync) begin
      sh_clr = 1'b1;
      sh_en  = sin_en;
    end else if (sin_en) begin
      case (state)
        IDLE: sh_en = 1'b1;
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef SIPO_PARITY_EN
            sh_en = 1'b1;
`else
            done   = 1'b1;
            sh_clr = 1'b1;
`endif
          end else begin
            sh_en = 1'b1;
          end
        end
        PARITY: begin
          done   = 1'b1;
          sh_clr = 1'b1;
        end
        default: sh_en = 1'b0;
      endcase
    end
`ifdef SIPO_PARITY_EN
    word     = sh;
    word_par = ^{sh, sin};
`else
    word = {sh[WIDTH-2:0], sin};
`endif
  end

  // FSM, bit counter, holding register and flags.
  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (sync) begin
        state <= sin_en ? SHIFT : IDLE;
        cnt   <= sin_en ? CW'(1) : '0;
        busy  <= sin_en;
      end else if (sin_en) begin
        case (state)
          IDLE: begin
            state <= SHIFT;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
          SHIFT: begin
            if (cnt == LAST) begin
`ifdef SIPO_PARITY_EN
              state <= PARITY;
              cnt   <= cnt + CW'(1);
`else
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PARITY: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end

      if (done) begin
        if (dout_valid && !dout_ready) begin
          overrun <= 1'b1;
        end else begin
          dout       <= word;
          dout_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
          parity_err <= word_par;
`endif
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
